// File: rtl/enc_byte_serializer_pkg.sv
// Shared widths, encryptor latency and serializer state type for the
// encryptor-output byte serializer.
package enc_pkg;
  localparam int WORD_W         = 32;
  localparam int BYTE_W         = 8;
  localparam int BYTES_PER_WORD = 4;
  localparam int ENC_LATENCY    = 13;
  localparam int IDX_W          = $clog2(BYTES_PER_WORD);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } ser_state_e;
endpackage

// File: rtl/enc_byte_serializer_if.sv
// Word-in / byte-out signal bundle between the encryptor side, the serializer
// and the byte sink.
interface enc_byte_serializer_if #(
  parameter int DEPTH = 8
) ();
  import enc_pkg::*;
  localparam int FILL_W = $clog2(DEPTH) + 1;

  logic              WORD_VALID;
  logic [WORD_W-1:0] ENC_D;
  logic [BYTE_W-1:0] BYTE_OUT;
  logic              BYTE_VALID;
  logic              BYTE_READY;
  logic              OVERFLOW;
  logic [FILL_W-1:0] FILL;

  modport master (
    output WORD_VALID, ENC_D, BYTE_READY,
    input  BYTE_OUT, BYTE_VALID, OVERFLOW, FILL
  );

  modport slave (
    input  WORD_VALID, ENC_D, BYTE_READY,
    output BYTE_OUT, BYTE_VALID, OVERFLOW, FILL
  );
endinterface

// File: rtl/enc_byte_serializer_fifo.sv
// Synchronous word FIFO; head word is presented continuously and the pop
// edge advances the read pointer so the consumer's register captures it.
module enc_word_fifo
  import enc_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push_i,
  input  logic [WORD_W-1:0] wr_data_i,
  input  logic              pop_i,
  output logic [WORD_W-1:0] rd_data_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [AW:0]       count_o
);
  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic              push_ok, pop_ok;

  assign full_o    = (count_q == (AW+1)'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign rd_data_o = mem_q[rd_ptr_q];

  // A push into a full FIFO is legal only when the head leaves on the same edge.
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (push_ok && !pop_ok)      count_d = count_q + (AW+1)'(1);
    else if (pop_ok && !push_ok) count_d = count_q - (AW+1)'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= wr_data_i;
  end
endmodule

// File: rtl/enc_byte_serializer.sv
// Tracks valid encryptor outputs with a latency-matched delay line, queues
// them, and streams each word MSB byte first over a ready/valid byte port.
module enc_byte_serializer
  import enc_pkg::*;
#(
  parameter  int LATENCY = ENC_LATENCY,
  parameter  int DEPTH   = 8,
  localparam int AW      = $clog2(DEPTH)
) (
  input logic                 CLK,
  input logic                 RST,
  enc_byte_serializer_if.slave bus
);
  logic [LATENCY-1:0] vld_dly_q, vld_dly_d;
  logic               tap;

  ser_state_e         state_q, state_d;
  logic [WORD_W-1:0]  shift_q, shift_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               ovf_q, ovf_d;

  logic               push, pop;
  logic [WORD_W-1:0]  fifo_head;
  logic               fifo_full, fifo_empty;
  logic [AW:0]        fifo_count;

  // Encryptor carries no valid flag, so its result is qualified by this tap.
  assign vld_dly_d = {vld_dly_q[LATENCY-2:0], bus.WORD_VALID};
  assign tap       = vld_dly_q[LATENCY-1];

  assign push  = tap && (!fifo_full || pop);
  assign ovf_d = ovf_q || (tap && fifo_full && !pop);

  enc_word_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i     (CLK),
    .rst_i     (RST),
    .push_i    (push),
    .wr_data_i (bus.ENC_D),
    .pop_i     (pop),
    .rd_data_o (fifo_head),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .count_o   (fifo_count)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      vld_dly_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      vld_dly_q <= vld_dly_d;
      ovf_q     <= ovf_d;
    end
  end

  always_ff @(posedge CLK) begin
    shift_q <= shift_d;
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_head;
          idx_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (bus.BYTE_READY) begin
          if (idx_q != IDX_W'(BYTES_PER_WORD - 1)) begin
            shift_d = {shift_q[WORD_W-BYTE_W-1:0], {BYTE_W{1'b0}}};
            idx_d   = idx_q + IDX_W'(1);
          end else if (!fifo_empty) begin
            // Reload on the last byte so consecutive words stream without a bubble.
            pop     = 1'b1;
            shift_d = fifo_head;
            idx_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.BYTE_VALID = (state_q == SEND);
    bus.BYTE_OUT   = (state_q == SEND) ? shift_q[WORD_W-1 -: BYTE_W] : '0;
    bus.OVERFLOW   = ovf_q;
    bus.FILL       = fifo_count;
  end
endmodule

// File: tb/tb_enc_byte_serializer.sv
// Directed and randomized checks of the byte serializer against a queue-based
// reference model that also plays the role of the encryptor.
module tb_enc_byte_serializer;
  import enc_pkg::*;

  localparam int L  = 13;
  localparam int D  = 8;
  localparam int HN = 4096;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  enc_byte_serializer_if #(.DEPTH(D)) bus ();

  enc_byte_serializer #(.LATENCY(L), .DEPTH(D)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  bit          hv [HN];
  logic [31:0] hw [HN];
  logic [31:0] mq [$];
  logic [31:0] cur = '0;
  int          r   = 0;
  bit          ovf = 1'b0;
  logic [7:0]  obs_b [$];
  int          obs_c [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("byte_valid", {31'd0, bus.BYTE_VALID}, (r != 0) ? 32'd1 : 32'd0);
    if (r != 0) chk("byte_out", {24'd0, bus.BYTE_OUT}, {24'd0, cur[31:24]});
    chk("fill", {28'd0, bus.FILL}, 32'(mq.size()));
    chk("overflow", {31'd0, bus.OVERFLOW}, {31'd0, ovf});
  endtask

  // One clock: check state, drive inputs, advance the model, cross the edge.
  task automatic step(input bit rst, input bit wv, input logic [31:0] w, input bit rdy);
    bit tap, pop;
    int sz0;
    check_outputs();
    if (cyc >= HN - 1) begin
      $display("FAIL cycle_budget cyc=%0d limit=%0d", cyc, HN - 1);
      $fatal(1, "cycle budget exhausted");
    end
    tap     = (cyc >= L) && hv[cyc - L];
    hv[cyc] = wv && !rst;
    hw[cyc] = w;
    RST            = rst;
    bus.WORD_VALID = wv;
    bus.BYTE_READY = rdy;
    bus.ENC_D      = tap ? hw[cyc - L] : $urandom();
    if (bus.BYTE_VALID && rdy) begin
      obs_b.push_back(bus.BYTE_OUT);
      obs_c.push_back(cyc);
    end
    if (rst) begin
      mq.delete();
      r   = 0;
      ovf = 1'b0;
      for (int i = 0; i <= cyc; i++) hv[i] = 1'b0;
    end else begin
      sz0 = mq.size();
      pop = (sz0 > 0) && (r == 0 || (r == 1 && rdy));
      if (r != 0 && rdy) begin
        r--;
        cur = cur << 8;
      end
      if (pop) begin
        cur = mq.pop_front();
        r   = 4;
      end
      if (tap) begin
        if (mq.size() < D) mq.push_back(hw[cyc - L]);
        else               ovf = 1'b1;
      end
    end
    @(posedge CLK);
    @(negedge CLK);
    cyc++;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 32'd0, 1);
  endtask

  task automatic clear_obs();
    obs_b.delete();
    obs_c.delete();
  endtask

  initial begin
    logic [7:0] e1 [4];
    logic [7:0] e2 [8];
    int n;

    RST = 1'b1;
    bus.WORD_VALID = 1'b0;
    bus.BYTE_READY = 1'b0;
    bus.ENC_D      = '0;
    @(posedge CLK);
    @(posedge CLK);
    @(negedge CLK);
    chk("rst_byte_valid", {31'd0, bus.BYTE_VALID}, 32'd0);
    chk("rst_byte_out",   {24'd0, bus.BYTE_OUT},   32'd0);
    chk("rst_overflow",   {31'd0, bus.OVERFLOW},   32'd0);
    chk("rst_fill",       {28'd0, bus.FILL},       32'd0);
    RST = 1'b0;

    // Single word, latency and byte order
    clear_obs();
    step(0, 1, 32'hA1B2C3D4, 1);
    n = 0;
    while (!bus.BYTE_VALID && n < 40) begin
      step(0, 0, 32'd0, 1);
      n++;
    end
    chk("first_valid_latency", 32'(n + 1), 32'(L + 2));
    drain(8);
    e1 = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    chk("single_count", 32'(obs_b.size()), 32'd4);
    for (int i = 0; i < 4 && i < obs_b.size(); i++) chk("single_byte", {24'd0, obs_b[i]}, {24'd0, e1[i]});

    // Backpressure in the middle of a word
    clear_obs();
    step(0, 1, 32'h11223344, 1);
    n = 0;
    while (r != 3 && n < 40) begin
      step(0, 0, 32'd0, 1);
      n++;
    end
    for (int i = 0; i < 5; i++) step(0, 0, 32'd0, 0);
    drain(8);
    e1 = '{8'h11, 8'h22, 8'h33, 8'h44};
    chk("bp_count", 32'(obs_b.size()), 32'd4);
    for (int i = 0; i < 4 && i < obs_b.size(); i++) chk("bp_byte", {24'd0, obs_b[i]}, {24'd0, e1[i]});

    // Back-to-back words stream without a gap
    clear_obs();
    step(0, 1, 32'h01020304, 1);
    step(0, 1, 32'h05060708, 1);
    drain(L + 14);
    e2 = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    chk("b2b_count", 32'(obs_b.size()), 32'd8);
    for (int i = 0; i < 8 && i < obs_b.size(); i++) chk("b2b_byte", {24'd0, obs_b[i]}, {24'd0, e2[i]});
    if (obs_b.size() == 8) chk("b2b_no_gap", 32'(obs_c[7] - obs_c[0]), 32'd7);
    chk("b2b_fill_zero", {28'd0, bus.FILL}, 32'd0);

    // Overflow with the sink stalled
    step(1, 0, 32'd0, 0);
    for (int i = 0; i < 20; i++) step(0, 1, $urandom(), 0);
    for (int i = 0; i < L + 4; i++) step(0, 0, 32'd0, 0);
    chk("ovf_fill_sat", {28'd0, bus.FILL}, 32'd8);
    chk("ovf_set", {31'd0, bus.OVERFLOW}, 32'd1);
    drain(60);
    chk("ovf_sticky", {31'd0, bus.OVERFLOW}, 32'd1);
    chk("ovf_drained", {28'd0, bus.FILL}, 32'd0);

    // Full FIFO while pops occur: arrivals coincide with pops
    step(1, 0, 32'd0, 0);
    for (int i = 0; i < 20; i++) step(0, 1, $urandom(), 0);
    for (int i = 0; i < 30; i++) step(0, 1, $urandom(), 1);
    drain(L + 60);

    // Randomized traffic
    step(1, 0, 32'd0, 0);
    for (int i = 0; i < 400; i++) step(0, ($urandom % 4) == 0, $urandom(), ($urandom % 10) < 7);
    drain(L + 60);

    // Reset in the middle of a word with words queued and in flight
    step(1, 0, 32'd0, 0);
    for (int i = 0; i < 8; i++) step(0, 1, $urandom(), 1);
    n = 0;
    while (r != 3 && n < 40) begin
      step(0, 0, 32'd0, 1);
      n++;
    end
    step(1, 0, 32'd0, 1);
    chk("midrst_byte_valid", {31'd0, bus.BYTE_VALID}, 32'd0);
    chk("midrst_byte_out",   {24'd0, bus.BYTE_OUT},   32'd0);
    chk("midrst_fill",       {28'd0, bus.FILL},       32'd0);
    chk("midrst_overflow",   {31'd0, bus.OVERFLOW},   32'd0);
    clear_obs();
    drain(40);
    chk("midrst_no_bytes", 32'(obs_b.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
